instr_assembler: RTL
====================

# instr_assembler

Streaming instruction-word assembler for the MIPS test/load path: the inverse of the field-splitting decoder. It accepts per-instruction field bundles (R/I/J format or raw word) through a valid/ready handshake and packs each into a 32-bit word. It then writes the word into instruction memory at consecutive word addresses starting at a programmable base PC. It sits between the bench/boot loader and the IM write port, and reports progress, capacity and completion.

## Interface
- `ADDR_W`, 12: IM word-address width; capacity 2^ADDR_W words.
- `BASE_PC`, 32'h0000_3000: byte PC of word address 0.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begins a load session.
- `finish`  in  1  pulse; ends the session.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  assembler can accept.
- `fmt`  in  2  0=R, 1=I, 2=J, 3=RAW.
- `opcode`  in  6; `rs`, `rt`, `rd`, `shamt`  in  5 each; `funct`  in  6.
- `imm16`  in  16; `imm26`  in  26; `raw`  in  32.
- `im_we`  out  1  IM write strobe.
- `im_addr`  out  ADDR_W  word address.
- `im_wdata`  out  32  packed word.
- `pc_out`  out  32  BASE_PC + {im_addr,2'b00}.
- `count`  out  ADDR_W+1  words written this session.
- `full`  out  1  count == 2^ADDR_W.
- `done`  out  1  session closed and drained.
- `err`  out  1  sticky format error (only with check macro).

## Operation
- States: IDLE, LOAD, DONE. Reset enters IDLE.
- IDLE: in_ready=0. A `start` pulse clears count, clears err, and moves to LOAD.
- LOAD: in_ready = !full. A transfer occurs when in_valid && in_ready; the packed word and its address are registered.
- `finish` pulse in LOAD moves to DONE. A transfer in the same cycle as finish is still accepted and written.
- DONE: in_ready=0. `done` = !im_we, i.e. asserted once the write stage is empty. `start` re-enters LOAD with count cleared.
- `start` in LOAD restarts the session: count is cleared, and a word already registered is still written at its old address.
- Packing:
  - R: {opcode,rs,rt,rd,shamt,funct}.
  - I: {opcode,rs,rt,imm16}.
  - J: {opcode,imm26}.
  - RAW: raw.
  - Unused fields are ignored.
- Address = count at acceptance. count increments by 1 per accepted word, saturates at 2^ADDR_W (full), and never wraps.
- in_valid while in_ready=0: ignored and not buffered; the source must hold the bundle.

## Timing
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, pc_out=BASE_PC, count=0, full=0, done=0, err=0.
- Latency: a bundle accepted at edge N drives im_we=1 with addr/wdata/pc_out during cycle N+1. im_we is a 1-cycle strobe per word.
- Throughput: 1 word/cycle, back-to-back.
- count/full update at the acceptance edge. in_ready drops in the same cycle full becomes 1.
- Reset mid-session discards the registered word: im_we=0 in the cycle after reset.

## Configuration
- `INSTR_ASM_CHECK_EN` defined:
  - R format with opcode!=0, or J format with opcode not 2/3, sets sticky `err`.
  - That word is accepted (handshake completes) but not written (im_we stays 0) and count does not advance.
- Undefined: no checking; every accepted word is written; `err` is tied 0.

## Structure
- Shared header `instr_asm_defs.vh`: format codes FMT_R/FMT_I/FMT_J/FMT_RAW, state encodings, opcode constants OP_SPECIAL=0, OP_J=2, OP_JAL=3.
- Sub-module `instr_pack`: purely combinational fmt+fields → 32-bit word. It mirrors the splitter's bit positions and is instantiated once.
- Top level holds the FSM, count, write-stage register and check logic.

## Test plan
- start; R addu (rs=1, rt=2, rd=3, funct=0x21) → next cycle im_we=1, im_addr=0, im_wdata=0x00221821, pc_out=0x00003000, count=1.
- Back-to-back I ori (op 0x0D, rt=1, imm16=0x1234) then J (op 2, imm26=0x0000C00) → 0x34011234 @addr0 and 0x08000C00 @addr1 on consecutive cycles, pc_out 0x3000, 0x3004.
- ADDR_W=2: stream 5 words → 4 written, full=1 and in_ready=0 after the 4th, 5th held pending, count=4.
- finish coincident with a transfer → that word written next cycle; done=1 the cycle after im_we falls.
- reset asserted the cycle after an acceptance → im_we=0, count=0, state IDLE, in_ready=0.
- With INSTR_ASM_CHECK_EN: R format with opcode=0x23 → err=1, no im_we, count unchanged; a following valid word is written at the same address.

Source files
------------

// File: rtl/instr_assembler_pkg.sv
// Shared definitions for the instruction assembler: format codes, FSM encodings,
// opcode constants and the format-legality check.
package instr_assembler_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_RAW = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;

  // R words must carry SPECIAL; J words must be j or jal.
  function automatic logic fmt_illegal(input logic [1:0] fmt, input logic [5:0] opcode);
    fmt_illegal = ((fmt == FMT_R) && (opcode != OP_SPECIAL)) ||
                  ((fmt == FMT_J) && (opcode != OP_J) && (opcode != OP_JAL));
  endfunction

endpackage

// File: rtl/instr_assembler_pack.sv
// Combinational field packer: format code plus fields to a 32-bit MIPS word,
// using the same bit positions as the field splitter.
module instr_assembler_pack
  import instr_assembler_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] raw,
  output logic [31:0] word
);

  always_comb begin
    word = raw;
    unique case (fmt)
      FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   word = {opcode, rs, rt, imm16};
      FMT_J:   word = {opcode, imm26};
      default: word = raw;
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Streaming instruction assembler: packs field bundles and writes them to IM at
// consecutive word addresses. Optional format checking under INSTR_ASM_CHECK_EN.
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [31:0]       raw,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [31:0]       pc_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       packed_word;
  logic              fire;
  logic              bad;
  logic              wr;

  instr_assembler_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16),
    .imm26  (imm26),
    .raw    (raw),
    .word   (packed_word)
  );

  // Capacity is a power of two, so the count MSB is exactly the full flag.
  assign full     = count_q[ADDR_W];
  assign in_ready = (state_q == ST_LOAD) && !full;
  assign fire     = in_valid && in_ready;

`ifdef INSTR_ASM_CHECK_EN
  logic err_q, err_d;

  assign bad = fmt_illegal(fmt, opcode);
  assign err = err_q;

  always_comb begin
    err_d = err_q;
    if (start)           err_d = 1'b0;
    else if (fire && bad) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  assign wr = fire && !bad;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (wr) count_d = count_q + 1'b1;
    if (start) begin
      // Restart wins over a same-cycle transfer for the count; the word still lands.
      count_d = '0;
      state_d = ST_LOAD;
    end else if (finish && (state_q == ST_LOAD)) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= wr;
      if (wr) begin
        addr_q  <= count_q[ADDR_W-1:0];
        wdata_q <= packed_word;
      end
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign pc_out   = BASE_PC + 32'({addr_q, 2'b00});
  assign count    = count_q;
  assign done     = (state_q == ST_DONE) && !we_q;

endmodule
